// File: rtl/mmu_port_arbiter.sv
// N-channel arbiter in front of the single l1mmu line port: one outstanding transaction, latched payload.
// Define MMU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module mmu_port_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_done,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     mmu_read,
  output logic                     mmu_write,
  output logic [ADDR_W-1:0]        mmu_addr,
  output logic [DATA_W-1:0]        mmu_wdata,
  input  logic                     mmu_done,
  input  logic [DATA_W-1:0]        mmu_rdata,
  output logic                     grant_valid,
  output logic [CH_W-1:0]          grant_id
);

  // Handshake: a channel holds req_read/req_write (level) until it sees its one-cycle req_done;
  // the l1mmu side sees a latched request held until its one-cycle mmu_done.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_id_q, grant_id_d;
  logic              mmu_read_q, mmu_read_d;
  logic              mmu_write_q, mmu_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NUM_CH-1:0] req_any;
  logic [CH_W-1:0]   rr_base;
  logic [CH_W-1:0]   rr_next;
  logic              win_found;
  int                win_idx;
  int                scan_idx;

`ifdef MMU_ARB_FIXED_PRIO_EN
  assign rr_base = '0;
`else
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  assign rr_base = rr_ptr_q;
`endif

  assign req_any = req_read | req_write;
  assign rr_next = (grant_id_q == CH_W'(NUM_CH - 1)) ? '0 : grant_id_q + 1'b1;

  // First requester at or after rr_base, wrapping modulo NUM_CH.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = int'(rr_base) + k;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      if (!win_found && req_any[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    mmu_read_d  = mmu_read_q;
    mmu_write_d = mmu_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifndef MMU_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = BUSY;
          grant_id_d  = CH_W'(win_idx);
          mmu_write_d = req_write[win_idx];
          mmu_read_d  = req_read[win_idx] & ~req_write[win_idx];
          addr_d      = req_addr[win_idx*ADDR_W +: ADDR_W];
          wdata_d     = req_wdata[win_idx*DATA_W +: DATA_W];
        end
      end
      BUSY: begin
        if (mmu_done) begin
          state_d     = IDLE;
          mmu_read_d  = 1'b0;
          mmu_write_d = 1'b0;
`ifndef MMU_ARB_FIXED_PRIO_EN
          rr_ptr_d    = rr_next;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      mmu_read_q  <= 1'b0;
      mmu_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifndef MMU_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      mmu_read_q  <= mmu_read_d;
      mmu_write_q <= mmu_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifndef MMU_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  // Completion is only forwarded while a transaction is outstanding; a done in IDLE is dropped.
  always_comb begin
    req_done = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_done[i] = (state_q == BUSY) && mmu_done && (grant_id_q == CH_W'(i));
    end
  end

  assign req_rdata   = mmu_rdata;
  assign mmu_read    = mmu_read_q;
  assign mmu_write   = mmu_write_q;
  assign mmu_addr    = addr_q;
  assign mmu_wdata   = wdata_q;
  assign grant_valid = (state_q == BUSY);
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Self-checking bench for mmu_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mmu_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int CW = 1;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_read;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_done;
  logic [DW-1:0]   req_rdata;
  logic            mmu_read;
  logic            mmu_write;
  logic [AW-1:0]   mmu_addr;
  logic [DW-1:0]   mmu_wdata;
  logic            mmu_done;
  logic [DW-1:0]   mmu_rdata;
  logic            grant_valid;
  logic [CW-1:0]   grant_id;

  mmu_port_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .sys_clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata),
    .mmu_done(mmu_done), .mmu_rdata(mmu_rdata),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // transaction-level reference model
  bit            m_busy;
  int            m_gid;
  int            m_ptr;
  logic          m_read, m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [CW-1:0] exp_q[$];

  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_done();
    logic [N-1:0] one;
    one = 1;
    return (m_busy && mmu_done) ? (one << m_gid) : '0;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // driver: advance one clock, updating the model from the inputs driven this cycle
  task automatic step();
    int w;
    if (rst) begin
      m_busy = 0; m_gid = 0; m_ptr = 0; m_read = 0; m_write = 0;
      m_addr = '0; m_wdata = '0;
      exp_q.delete();
    end else if (!m_busy) begin
`ifdef MMU_ARB_FIXED_PRIO_EN
      w = pick(req_read | req_write, 0);
`else
      w = pick(req_read | req_write, m_ptr);
`endif
      if (w >= 0) begin
        m_busy  = 1;
        m_gid   = w;
        m_write = req_write[w];
        m_read  = req_read[w] && !req_write[w];
        m_addr  = req_addr[w*AW +: AW];
        m_wdata = req_wdata[w*DW +: DW];
        exp_q.push_back(CW'(w));
      end
    end else if (mmu_done) begin
      m_busy = 0; m_read = 0; m_write = 0;
      m_ptr  = (m_gid + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_read = 2'b11; req_write = 2'b01;
    req_addr = {32'hDEAD_0000, 32'hBEEF_0000};
    step();
    req_read = '0; req_write = '0;
    step();
    checks++;
    if (grant_valid !== 1'b0 || grant_id !== '0 || mmu_read !== 1'b0 || mmu_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got gv=%b gid=%0d rd=%b wr=%b want all 0", grant_valid, grant_id, mmu_read, mmu_write);
    end
    checks++;
    if (mmu_addr !== '0 || mmu_wdata !== '0 || req_done !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h done=%b want 0", mmu_addr, req_done);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (mmu_read !== 1'b0 || mmu_write !== 1'b0 || grant_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet: cycle %0d got rd=%b wr=%b gv=%b want 0", c, mmu_read, mmu_write, grant_valid);
      end
    end
  endtask

  task automatic test_single_read();
    logic [DW-1:0] a5;
    a5 = {8{32'hA5A5_A5A5}};
    req_addr[AW +: AW] = 32'h0000_1000;
    req_read = 2'b10;
    step();
    checks++;
    if (mmu_read !== 1'b1 || mmu_write !== 1'b0 || mmu_addr !== 32'h0000_1000 || grant_valid !== 1'b1 || grant_id !== 1'b1) begin
      failures++;
      $display("FAIL single_issue: got rd=%b wr=%b addr=%h gv=%b gid=%0d want 1 0 00001000 1 1",
               mmu_read, mmu_write, mmu_addr, grant_valid, grant_id);
    end
    step(); step(); step();
    mmu_done = 1'b1; mmu_rdata = a5;
    #1;
    checks++;
    if (req_done !== 2'b10 || req_rdata !== a5) begin
      failures++;
      $display("FAIL single_done: got done=%b rdata=%h want 10 %h", req_done, req_rdata, a5);
    end
    req_read = '0;
    step();
    mmu_done = 1'b0;
    checks++;
    if (mmu_read !== 1'b0 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_release: got rd=%b gv=%b want 0 0", mmu_read, grant_valid);
    end
  endtask

  task automatic test_contention();
    int cnt;
    int exp_ch;
    logic [N-1:0] one;
    one = 1;
    req_addr = {32'h0000_0200, 32'h0000_0100};
    req_read = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef MMU_ARB_FIXED_PRIO_EN
      exp_ch = 0;
`else
      exp_ch = k % 2;
`endif
      cnt = 0;
      while (!grant_valid && cnt < 10) begin
        step();
        cnt++;
      end
      checks++;
      if (!grant_valid || cnt != 1) begin
        failures++;
        $display("FAIL contention_gap: txn %0d got %0d idle cycles (gv=%b) want 1", k, cnt, grant_valid);
      end
      checks++;
      if (grant_id !== CW'(exp_ch) || mmu_addr !== AW'(32'h100 * (exp_ch + 1))) begin
        failures++;
        $display("FAIL contention_order: txn %0d got gid=%0d addr=%h want %0d", k, grant_id, mmu_addr, exp_ch);
      end
      step(); step();
      mmu_done = 1'b1;
      #1;
      checks++;
      if (req_done !== (one << exp_ch)) begin
        failures++;
        $display("FAIL contention_done: txn %0d got %b want %b", k, req_done, one << exp_ch);
      end
      step();
      mmu_done = 1'b0;
    end
    req_read = '0;
    step();
  endtask

  task automatic test_write_latch();
    logic [DW-1:0] wd;
    wd = rand_line();
    req_read = 2'b01; req_write = 2'b01;
    req_addr[0 +: AW] = 32'h40;
    req_wdata[0 +: DW] = wd;
    step();
    req_addr[0 +: AW] = 32'h80;
    req_wdata[0 +: DW] = rand_line();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (mmu_write !== 1'b1 || mmu_read !== 1'b0 || mmu_addr !== 32'h40 || mmu_wdata !== wd) begin
        failures++;
        $display("FAIL write_latch: cycle %0d got wr=%b rd=%b addr=%h want 1 0 00000040", c, mmu_write, mmu_read, mmu_addr);
      end
      step();
    end
    mmu_done = 1'b1;
    #1;
    checks++;
    if (req_done !== 2'b01) begin
      failures++;
      $display("FAIL write_done: got %b want 01", req_done);
    end
    req_read = '0; req_write = '0;
    step();
    mmu_done = 1'b0;
    checks++;
    if (mmu_write !== 1'b0 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL write_release: got wr=%b gv=%b want 0 0", mmu_write, grant_valid);
    end
  endtask

  task automatic test_spurious_done();
    mmu_done = 1'b1;
    #1;
    checks++;
    if (req_done !== '0) begin
      failures++;
      $display("FAIL spurious_done: got %b want 00", req_done);
    end
    step();
    mmu_done = 1'b0;
    checks++;
    if (grant_valid !== 1'b0 || mmu_read !== 1'b0 || mmu_write !== 1'b0) begin
      failures++;
      $display("FAIL spurious_state: got gv=%b want 0", grant_valid);
    end
  endtask

  task automatic test_drop();
    req_addr[AW +: AW] = 32'h0000_3000;
    req_read = 2'b10;
    step();
    req_read = '0;
    step(); step();
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 1'b1 || mmu_read !== 1'b1 || mmu_addr !== 32'h3000) begin
      failures++;
      $display("FAIL drop_hold: got gv=%b gid=%0d rd=%b addr=%h want 1 1 1 00003000", grant_valid, grant_id, mmu_read, mmu_addr);
    end
    mmu_done = 1'b1;
    #1;
    checks++;
    if (req_done !== 2'b10) begin
      failures++;
      $display("FAIL drop_done: got %b want 10", req_done);
    end
    step();
    mmu_done = 1'b0;
  endtask

  task automatic test_reset_busy();
    req_write = 2'b01;
    req_addr[0 +: AW] = 32'h0000_5000;
    req_wdata[0 +: DW] = rand_line();
    step();
    checks++;
    if (grant_valid !== 1'b1 || mmu_write !== 1'b1) begin
      failures++;
      $display("FAIL rstbusy_issue: got gv=%b wr=%b want 1 1", grant_valid, mmu_write);
    end
    rst = 1'b1; req_write = '0;
    step();
    rst = 1'b0;
    checks++;
    if (grant_valid !== 1'b0 || mmu_write !== 1'b0 || mmu_addr !== '0 || mmu_wdata !== '0 || grant_id !== '0) begin
      failures++;
      $display("FAIL rstbusy_clear: got gv=%b wr=%b addr=%h want 0 0 0", grant_valid, mmu_write, mmu_addr);
    end
    mmu_done = 1'b1;
    #1;
    checks++;
    if (req_done !== '0) begin
      failures++;
      $display("FAIL rstbusy_lost_done: got %b want 00", req_done);
    end
    step();
    mmu_done = 1'b0;
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstbusy_idle: got gv=%b want 0", grant_valid);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ed;
    logic [CW-1:0] exp_ch;
    int got;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      req_read  = N'($urandom_range(0, 3));
      req_write = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 3)) : '0;
      req_addr  = {$urandom, $urandom};
      req_wdata = {rand_line(), rand_line()};
      mmu_rdata = rand_line();
      mmu_done  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      #1;
      ed = exp_done();
      checks++;
      if (req_done !== ed || req_rdata !== mmu_rdata) begin
        failures++;
        $display("FAIL rand_done: cycle %0d got %b want %b", c, req_done, ed);
      end
      if (ed != '0) begin
        exp_ch = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        got = -1;
        for (int i = 0; i < N; i++) if (req_done[i] === 1'b1) got = i;
        checks++;
        if (got != int'(exp_ch)) begin
          failures++;
          $display("FAIL rand_sb: cycle %0d completed ch %0d want %0d", c, got, exp_ch);
        end
      end
      step();
      checks++;
      if (grant_valid !== m_busy || mmu_read !== m_read || mmu_write !== m_write ||
          mmu_addr !== m_addr || mmu_wdata !== m_wdata || (m_busy && grant_id !== CW'(m_gid))) begin
        failures++;
        $display("FAIL rand_state: cycle %0d got gv=%b gid=%0d rd=%b wr=%b addr=%h want %b %0d %b %b %h",
                 c, grant_valid, grant_id, mmu_read, mmu_write, mmu_addr, m_busy, m_gid, m_read, m_write, m_addr);
      end
    end
    req_read = '0; req_write = '0; mmu_done = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mmu_done = 1'b0; mmu_rdata = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_latch();
    test_spurious_done();
    test_drop();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
